// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - issue/writeback handshake bundle for alu_multicycle
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy;

  // Issue stage / writeback consumer side
  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  // ALU side
  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle chunked add/sub + logic ALU with NZCV flags (optional ALU_SAT_EN saturation)
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_multicycle_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;        // B already inverted for subtraction
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic             out_valid_q;
`ifdef ALU_SAT_EN
  logic             sat_q;
`endif

  logic [CHUNK:0]   sum_d;
  logic [WIDTH-1:0] sum_result_d;
  logic [WIDTH-1:0] final_result_d;
  logic [WIDTH-1:0] logic_result_d;
  logic [3:0]       arith_flags_d;
  logic             v_d;
  int               base_d;

  function automatic logic op_is_arith(input logic [2:0] op);
`ifdef ALU_SAT_EN
    return (op == 3'b000) || (op == 3'b001) || (op[2:1] == 2'b11);
`else
    return (op == 3'b000) || (op == 3'b001);
`endif
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
`ifdef ALU_SAT_EN
    return (op == 3'b001) || (op == 3'b111);
`else
    return (op == 3'b001);
`endif
  endfunction

  // One CHUNK-wide carry-chain slice plus the final-slice flag/saturation view
  always_comb begin
    base_d       = int'(k_q) * CHUNK;
    sum_d        = {1'b0, a_q[base_d +: CHUNK]} + {1'b0, b_q[base_d +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry_q};
    sum_result_d = result_q;
    sum_result_d[base_d +: CHUNK] = sum_d[CHUNK-1:0];
    // b_q holds ~B for sub, so one sign rule covers both directions
    v_d            = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_result_d[WIDTH-1] != a_q[WIDTH-1]);
    final_result_d = sum_result_d;
`ifdef ALU_SAT_EN
    if (sat_q && v_d) begin
      final_result_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    arith_flags_d = {final_result_d[WIDTH-1], (final_result_d == '0), sum_d[CHUNK], v_d};
  end

  // Logic/reserved ops resolve directly from the offered operands in the accept cycle
  always_comb begin
    logic_result_d = '0;
    case (bus.opcode)
      3'b010:  logic_result_d = bus.A & bus.B;
      3'b011:  logic_result_d = bus.A | bus.B;
      3'b100:  logic_result_d = bus.A ^ bus.B;
      default: logic_result_d = '0;
    endcase
  end

  // Control FSM with registered datapath and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      k_q         <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.A;
            b_q     <= op_is_sub(bus.opcode) ? ~bus.B : bus.B;
            k_q     <= '0;
            carry_q <= op_is_sub(bus.opcode);
`ifdef ALU_SAT_EN
            sat_q   <= (bus.opcode[2:1] == 2'b11);
`endif
            if (op_is_arith(bus.opcode)) begin
              result_q <= '0;
              flags_q  <= '0;
              state_q  <= CALC;
            end else begin
              result_q <= logic_result_d;
              flags_q  <= {logic_result_d[WIDTH-1], (logic_result_d == '0), 2'b00};
              state_q  <= DONE;
            end
          end
        end
        CALC: begin
          carry_q <= sum_d[CHUNK];
          if (k_q == KW'(N - 1)) begin
            result_q    <= final_result_d;
            flags_q     <= arith_flags_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            result_q <= sum_result_d;
            k_q      <= k_q + 1'b1;
          end
        end
        DONE: begin
          // Logic ops arrive here at accept; valid is raised one cycle later
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle
module tb_alu_multicycle;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_multicycle_if #(.WIDTH(WIDTH)) bus ();

  alu_multicycle #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic in 64-bit integers, flags from value ranges
  function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, ut, st;
    logic [31:0] r;
    logic c, v, is_add, is_sub, sat;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = $signed(a);
    sb = $signed(b);
    r = '0; c = 1'b0; v = 1'b0; sat = 1'b0;
    is_add = (op == 3'd0);
    is_sub = (op == 3'd1);
`ifdef ALU_SAT_EN
    if (op == 3'd6) begin is_add = 1'b1; sat = 1'b1; end
    if (op == 3'd7) begin is_sub = 1'b1; sat = 1'b1; end
`endif
    if (is_add) begin
      ut = ua + ub; st = sa + sb;
      r = ut[31:0];
      c = (ut > 64'sh0FFFF_FFFF);
      v = (st > 64'sh7FFF_FFFF) || (st < -64'sh8000_0000);
    end else if (is_sub) begin
      ut = ua - ub; st = sa - sb;
      r = ut[31:0];
      c = (ua >= ub);
      v = (st > 64'sh7FFF_FFFF) || (st < -64'sh8000_0000);
    end else begin
      case (op)
        3'd2:    r = a & b;
        3'd3:    r = a | b;
        3'd4:    r = a ^ b;
        default: r = '0;
      endcase
    end
    if (sat && v) r = (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic int exp_latency(input logic [2:0] op);
`ifdef ALU_SAT_EN
    if (op == 3'd0 || op == 3'd1 || op == 3'd6 || op == 3'd7) return NCH;
`else
    if (op == 3'd0 || op == 3'd1) return NCH;
`endif
    return 1;
  endfunction

  // Issue one op, measure latency, check result/flags, hold back-pressure, then drain
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int bp);
    logic [35:0] exp;
    int lat;
    exp = model(op, a, b);
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.opcode = op; bus.A = a; bus.B = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.opcode = 3'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 50);
    chk({tag, "_latency"}, lat, exp_latency(op));
    chk({tag, "_result"}, bus.result, exp[31:0]);
    chk({tag, "_flags"}, bus.flags, exp[35:32]);
    chk({tag, "_busy"}, bus.busy, 1);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom); bus.A = $urandom; bus.B = $urandom;
      chk({tag, "_bp_in_ready"}, bus.in_ready, 0);
      chk({tag, "_bp_valid"}, bus.out_valid, 1);
      chk({tag, "_bp_result"}, bus.result, exp[31:0]);
      chk({tag, "_bp_flags"}, bus.flags, exp[35:32]);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, bus.out_valid, 0);
    chk({tag, "_in_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.A = '0; bus.B = '0; bus.opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", bus.flags, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;

    chk("plan_add_wrap_model", model(3'd0, 32'hFFFF_FFFF, 32'h1), {4'b0110, 32'h0});
    do_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op("sub_neg",  3'd1, 32'h0000_0005, 32'h0000_0007, 0);
    do_op("sub_pos",  3'd1, 32'h0000_0007, 32'h0000_0005, 0);
    do_op("add_ovf",  3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    do_op("sat_add",  3'd6, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    do_op("sat_sub",  3'd7, 32'h8000_0000, 32'h0000_0001, 0);
    do_op("xor",      3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 0);
    do_op("resv",     3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    do_op("bp_add",   3'd0, 32'h1234_5678, 32'h1111_1111, 5);

    // Reset two cycles into CALC aborts the op
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = 3'd0; bus.A = 32'd100; bus.B = 32'd200;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", bus.out_valid, 0);
    end
    do_op("post_rst_add", 3'd0, 32'd3, 32'd4, 0);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = (i % 4 == 0) ? ra : $urandom;
      do_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
